// File: rtl/cache_bus_mem_rsp.sv
// rtl/cache_bus_mem_rsp.sv - bus-side memory responder with block store and per-block cached flag
//
// Purpose: accepts one block request at a time on sdt_*, commits mem/flag updates at accept,
// and presents the registered response on sdr_* LATENCY cycles after accept.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   sdt_valid/sdt_ready   request handshake (ready only while idle)
//   sdt_op, sdt_addr      request opcode and block address
//   sdt_data              writeback data
//   sdr_valid/sdr_ready   response handshake
//   sdr_rsp, sdr_data     response code and block data
// Optional feature: define CACHE_BUS_MEM_RSP_ADDR_CHK_EN to return ERR for any request whose
// address has nonzero bits above the index field.
module cache_bus_mem_rsp #(
  parameter int PADDR_WIDTH = 32,
  parameter int BLK_WIDTH   = 512,
  parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8),
  parameter int NUM_ENTRY   = 16,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdt_valid,
  output logic                   sdt_ready,
  input  logic [2:0]             sdt_op,
  input  logic [SADDR_WIDTH-1:0] sdt_addr,
  input  logic [BLK_WIDTH-1:0]   sdt_data,
  output logic                   sdr_valid,
  input  logic                   sdr_ready,
  output logic [2:0]             sdr_rsp,
  output logic [BLK_WIDTH-1:0]   sdr_data
);

  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam int CNT_W = $clog2(LATENCY) + 1;

  localparam logic [2:0] OP_GETS = 3'd1;
  localparam logic [2:0] OP_GETX = 3'd2;
  localparam logic [2:0] OP_UPGR = 3'd3;
  localparam logic [2:0] OP_WB   = 3'd4;

  localparam logic [2:0] RSP_ACK    = 3'd0;
  localparam logic [2:0] RSP_DATA_S = 3'd1;
  localparam logic [2:0] RSP_DATA_E = 3'd2;
  localparam logic [2:0] RSP_ERR    = 3'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sdt_ready_q, sdt_ready_d;
  logic                   sdr_valid_q, sdr_valid_d;
  logic [2:0]             sdr_rsp_q, sdr_rsp_d;
  logic [BLK_WIDTH-1:0]   sdr_data_q, sdr_data_d;
  logic [BLK_WIDTH-1:0]   mem_q [NUM_ENTRY];
  logic [BLK_WIDTH-1:0]   mem_d [NUM_ENTRY];
  logic [NUM_ENTRY-1:0]   flag_q, flag_d;

  logic [IDX_W-1:0]       idx;
  logic                   addr_err;

  assign idx = sdt_addr[IDX_W-1:0];

`ifdef CACHE_BUS_MEM_RSP_ADDR_CHK_EN
  assign addr_err = |(sdt_addr >> IDX_W);
`else
  // Upper address bits alias onto the store; they are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(sdt_addr >> IDX_W);
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sdr_rsp_d  = sdr_rsp_q;
    sdr_data_d = sdr_data_q;
    mem_d      = mem_q;
    flag_d     = flag_q;
    case (state_q)
      IDLE: begin
        if (sdt_valid && sdt_ready_q) begin
          state_d    = WAIT;
          cnt_d      = CNT_W'(LATENCY - 1);
          sdr_data_d = '0;
          if (addr_err) begin
            sdr_rsp_d = RSP_ERR;
          end else begin
            case (sdt_op)
              OP_GETS: begin
                sdr_data_d  = mem_q[idx];
                sdr_rsp_d   = flag_q[idx] ? RSP_DATA_S : RSP_DATA_E;
                flag_d[idx] = 1'b1;
              end
              OP_GETX: begin
                sdr_data_d  = mem_q[idx];
                sdr_rsp_d   = RSP_DATA_E;
                flag_d[idx] = 1'b1;
              end
              OP_UPGR: begin
                sdr_rsp_d   = RSP_ACK;
                flag_d[idx] = 1'b1;
              end
              OP_WB: begin
                mem_d[idx]  = sdt_data;
                flag_d[idx] = 1'b0;
                sdr_rsp_d   = RSP_ACK;
              end
              default: sdr_rsp_d = RSP_ERR;
            endcase
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RSP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RSP: begin
        if (sdr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    sdt_ready_d = (state_d == IDLE);
    sdr_valid_d = (state_d == RSP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sdt_ready_q <= 1'b0;
      sdr_valid_q <= 1'b0;
      sdr_rsp_q   <= '0;
      sdr_data_q  <= '0;
      mem_q       <= '{default: '0};
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sdt_ready_q <= sdt_ready_d;
      sdr_valid_q <= sdr_valid_d;
      sdr_rsp_q   <= sdr_rsp_d;
      sdr_data_q  <= sdr_data_d;
      mem_q       <= mem_d;
      flag_q      <= flag_d;
    end
  end

  assign sdt_ready = sdt_ready_q;
  assign sdr_valid = sdr_valid_q;
  assign sdr_rsp   = sdr_rsp_q;
  assign sdr_data  = sdr_data_q;

endmodule
